nand_page_writer: RTL and testbench

NAND_PAGE_WRITER -- requirements
Module: nand_page_writer

---
 rtl/nand_page_writer.sv | 153 +++++++++++++++
 tb/tb_nand_page_writer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_page_writer.sv
// NAND page write sequencer: pops bytes from an upstream FIFO and strobes them onto the NAND bus.
// Optional XOR checksum of the written bytes when NAND_WR_CHECKSUM_EN is defined.
module nand_page_writer #(
  parameter int unsigned T_WP = 2,
  parameter int unsigned T_WH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] byte_count,
  input  logic        abort,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_read_en,
  output logic [7:0]  nand_io_out,
  output logic        nand_io_oe,
  output logic        nand_we_n,
  output logic        busy,
  output logic        done
`ifdef NAND_WR_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWeLow,
    StWeHigh,
    StDone
  } state_e;

  localparam logic [3:0] WpLast = 4'(T_WP - 1);
  localparam logic [3:0] WhLast = 4'(T_WH - 1);

  state_e      state_q;
  logic [11:0] remaining_q;
  logic [3:0]  timer_q;
  logic [7:0]  io_out_q;
  logic        io_oe_q;
  logic        we_n_q;
  logic        busy_q;
  logic        done_q;
`ifdef NAND_WR_CHECKSUM_EN
  logic [7:0]  checksum_q;
`endif

  // The pop must land in the same cycle the FETCH decision is made, so it stays combinational.
  assign fifo_read_en = (state_q == StFetch) && !fifo_empty;

  assign nand_io_out = io_out_q;
  assign nand_io_oe  = io_oe_q;
  assign nand_we_n   = we_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef NAND_WR_CHECKSUM_EN
  assign checksum    = checksum_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= 12'd0;
      timer_q     <= 4'd0;
      io_out_q    <= 8'h00;
      io_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef NAND_WR_CHECKSUM_EN
      checksum_q  <= 8'h00;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        timer_q <= 4'd0;
        io_oe_q <= 1'b0;
        we_n_q  <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              busy_q <= 1'b1;
`ifdef NAND_WR_CHECKSUM_EN
              checksum_q <= 8'h00;
`endif
              if (byte_count != 12'd0) begin
                remaining_q <= byte_count;
                state_q     <= StFetch;
              end else begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end
            end
          end
          StFetch: begin
            if (!fifo_empty) begin
              io_oe_q <= 1'b1;
              state_q <= StLoad;
            end
          end
          StLoad: begin
            io_out_q <= fifo_dout;
            we_n_q   <= 1'b0;
            timer_q  <= 4'd0;
            state_q  <= StWeLow;
`ifdef NAND_WR_CHECKSUM_EN
            checksum_q <= checksum_q ^ fifo_dout;
`endif
          end
          StWeLow: begin
            if (timer_q == WpLast) begin
              we_n_q  <= 1'b1;
              timer_q <= 4'd0;
              state_q <= StWeHigh;
            end else begin
              timer_q <= timer_q + 4'd1;
            end
          end
          StWeHigh: begin
            if (timer_q == WhLast) begin
              timer_q     <= 4'd0;
              io_oe_q     <= 1'b0;
              remaining_q <= remaining_q - 12'd1;
              // remaining is never zero here, so the decrement cannot wrap
              if (remaining_q == 12'd1) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                state_q <= StFetch;
              end
            end else begin
              timer_q <= timer_q + 4'd1;
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nand_page_writer.sv
// Scoreboard bench for nand_page_writer: stimulus pushes expected writes/completions, monitor checks.
module tb_nand_page_writer;

  localparam int TWP = 2;
  localparam int TWH = 2;
  localparam int P   = 2 + TWP + TWH;

  typedef struct {
    int         s;
    int         lat;
    bit         chk_lat;
    logic [7:0] csum;
  } done_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] byte_count = 12'd0;
  logic        abort = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic [7:0]  nand_io_out;
  logic        nand_io_oe;
  logic        nand_we_n;
  logic        busy;
  logic        done;

  logic        start2 = 1'b0;
  logic [11:0] byte_count2 = 12'd2;
  logic        abort2 = 1'b0;
  logic        empty2 = 1'b0;
  logic [7:0]  fifo_dout2 = 8'h00;
  logic        read_en2;
  logic [7:0]  io_out2;
  logic        oe2;
  logic        we_n2;
  logic        busy2;
  logic        done2;
`ifdef NAND_WR_CHECKSUM_EN
  logic [7:0]  checksum;
  logic [7:0]  checksum2;
`endif

  logic [7:0]  fifo_q[$];
  int          fifo_cnt = 0;
  logic        stall_force = 1'b0;
  logic        stall_en = 1'b0;
  logic        force_empty = 1'b0;
  logic [7:0]  exp_q[$];
  done_t       exp_done[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  int          d2 = 0;

  nand_page_writer #(.T_WP(TWP), .T_WH(TWH)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .byte_count  (byte_count),
    .abort       (abort),
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_read_en(fifo_read_en),
    .nand_io_out (nand_io_out),
    .nand_io_oe  (nand_io_oe),
    .nand_we_n   (nand_we_n),
    .busy        (busy),
    .done        (done)
`ifdef NAND_WR_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  nand_page_writer #(.T_WP(1), .T_WH(3)) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .byte_count  (byte_count2),
    .abort       (abort2),
    .fifo_dout   (fifo_dout2),
    .fifo_empty  (empty2),
    .fifo_read_en(read_en2),
    .nand_io_out (io_out2),
    .nand_io_oe  (oe2),
    .nand_we_n   (we_n2),
    .busy        (busy2),
    .done        (done2)
`ifdef NAND_WR_CHECKSUM_EN
    ,
    .checksum    (checksum2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: data appears the cycle after a pop.
  always @(posedge clk) begin
    if (fifo_read_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
    fifo_cnt    <= fifo_q.size();
    stall_force <= stall_en && ($urandom_range(0, 2) == 0);
  end
  assign fifo_empty = stall_force || force_empty || (fifo_cnt == 0);

  always @(posedge clk) begin
    if (read_en2) begin
      fifo_dout2 <= 8'(d2 * 17 + 3);
      d2 <= d2 + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pulse widths, data at the rising edge of we_n, completion timing.
  logic       prev_we_n = 1'b1;
  int         low_len = 0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (mon_en) begin
      done_t d;
      check("rd_while_empty", 32'(fifo_read_en && fifo_empty), 0);
      check("we_low_without_oe", 32'(!nand_we_n && !nand_io_oe), 0);
      check("idle_outputs", 32'(!busy && (!nand_we_n || nand_io_oe || fifo_read_en)), 0);
      if (!nand_we_n && prev_we_n) held = nand_io_out;
      if (!nand_we_n) begin
        low_len++;
        check("data_stable_low", nand_io_out, held);
      end
      if (nand_we_n && !prev_we_n) begin
        if (nand_io_oe) begin
          check("we_low_width", low_len, TWP);
          check("data_held_at_rise", nand_io_out, held);
          if (exp_q.size() == 0) check("unexpected_write", 1, 0);
          else check("write_data", nand_io_out, exp_q.pop_front());
        end
        low_len = 0;
      end
      prev_we_n = nand_we_n;
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = exp_done.pop_front();
          if (d.chk_lat) check("done_latency", cyc - d.s, d.lat);
`ifdef NAND_WR_CHECKSUM_EN
          check("checksum", checksum, d.csum);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom));
  endtask

  task automatic start_xfer(input int n, input bit chk_lat, input int extra, input bit poke);
    done_t      d;
    logic [7:0] cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(fifo_q[i]);
      cs ^= fifo_q[i];
    end
    d.s = cyc + 1;
    d.lat = n * P + extra;
    d.chk_lat = chk_lat;
    d.csum = cs;
    exp_done.push_back(d);
    start = 1'b1;
    byte_count = 12'(n);
    tick();
    start = 1'b0;
    if (poke && n > 0) begin
      start = 1'b1;
      byte_count = 12'($urandom);
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy !== 1'b0 && k < bound) begin
      tick();
      k++;
    end
    check("xfer_finishes", 32'(k < bound), 1);
  endtask

  // Abort or reset sampled a edges after the start edge; FIFO must hold exactly n bytes.
  task automatic abort_xfer(input int n, input int a, input bit use_rst);
    int wr = 0;
    int pp = 0;
    for (int i = 0; i < n; i++) begin
      if (i * P + 2 + TWP < a) wr++;
      if (i * P + 1 <= a) pp++;
    end
    for (int i = 0; i < wr; i++) exp_q.push_back(fifo_q[i]);
    start = 1'b1;
    byte_count = 12'(n);
    tick();
    start = 1'b0;
    repeat (a - 1) tick();
    if (use_rst) reset = 1'b1;
    else abort = 1'b1;
    tick();
    reset = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_we_n", nand_we_n, 1);
    check("abort_oe", nand_io_oe, 0);
    check("abort_done", done, 0);
    check("abort_fifo_left", fifo_q.size(), n - pp);
    if (use_rst) check("reset_io_out", nand_io_out, 0);
    tick();
  endtask

  int n;
  int mode;
  int s2;
  int pulses2;
  int low2;
  int last_rise2;
  bit seen2;
  logic prev2;

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we_n", nand_we_n, 1);
    check("rst_oe", nand_io_oe, 0);
    check("rst_io_out", nand_io_out, 0);
    check("rst_read_en", fifo_read_en, 0);
`ifdef NAND_WR_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // Three-byte page with known data
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h0F);
    start_xfer(3, 1'b1, 0, 1'b0);
    wait_idle(100);
    tick();

    // Zero-length request
    fill(2);
    start_xfer(0, 1'b1, 0, 1'b0);
    wait_idle(10);
    tick();
    check("zero_len_no_pop", fifo_q.size(), 2);

    // Five-cycle FIFO stall while fetching the second byte
    fill(2);
    start_xfer(2, 1'b1, 5, 1'b0);
    repeat (P) tick();
    force_empty = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_read_en", fifo_read_en, 0);
      check("stall_we_n", nand_we_n, 1);
      tick();
    end
    force_empty = 1'b0;
    wait_idle(100);
    tick();

    // Abort in the first WE_LOW cycle, then abort racing start in IDLE
    fill(3);
    abort_xfer(3, 3, 1'b0);
    fill(2);
    abort = 1'b1;
    start = 1'b1;
    byte_count = 12'd2;
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("abort_wins_busy", busy, 0);
    repeat (3) tick();
    check("abort_wins_no_pop", fifo_q.size(), 2);

    // Reset mid-pulse, then a clean single-byte write
    fill(3);
    abort_xfer(3, 3, 1'b1);
    fill(1);
    start_xfer(1, 1'b1, 0, 1'b0);
    wait_idle(50);
    tick();

    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 6);
      mode = $urandom_range(0, 4);
      fill(n);
      if (mode == 0 && n > 0) begin
        abort_xfer(n, $urandom_range(1, n * P), ($urandom_range(0, 3) == 0));
      end else begin
        stall_en = (mode == 1);
        start_xfer(n, (mode != 1), 0, (mode == 2));
        wait_idle(n * P * 4 + 50);
        stall_en = 1'b0;
      end
      repeat ($urandom_range(1, 3)) tick();
    end

    // Full-size page
    fill(4095);
    start_xfer(4095, 1'b1, 0, 1'b0);
    wait_idle(4095 * P + 100);
    tick();

    // Alternate timing instance: 1-cycle low, 3-cycle high
    start2 = 1'b1;
    s2 = cyc + 1;
    tick();
    start2 = 1'b0;
    pulses2 = 0;
    low2 = 0;
    last_rise2 = 0;
    seen2 = 1'b0;
    prev2 = 1'b1;
    for (int k = 0; k < 40 && !seen2; k++) begin
      @(negedge clk);
      if (!we_n2) low2++;
      if (we_n2 && !prev2) begin
        check("t2_low_width", low2, 1);
        check("t2_write_data", io_out2, 8'(pulses2 * 17 + 3));
        pulses2++;
        low2 = 0;
        last_rise2 = cyc;
      end
      prev2 = we_n2;
      if (done2) begin
        seen2 = 1'b1;
        check("t2_page_latency", cyc - s2, 12);
        check("t2_high_gap", cyc - last_rise2, 3);
        check("t2_pulses", pulses2, 2);
      end
    end
    check("t2_done_seen", 32'(seen2), 1);

    repeat (5) tick();
    check("writes_drained", exp_q.size(), 0);
    check("dones_drained", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
